seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Parametrised multiplexed seven-segment driver for the board display. It scans DIGITS common-anode digits and decodes a hex nibble per digit. Per-digit decimal-point and blanking control, leading-zero blanking and 16-level brightness are provided. A load/ready/ack handshake updates the displayed word only on frame boundaries, so the display never tears. It sits between the datapath producing a display word and the board's `an`/`seg` pins.

## Interface
- DIGITS, 4: number of digits scanned. Legal range 1..8.
- DIV_LOG2, 4: each digit slot lasts 2^DIV_LOG2 myclk cycles. Must be at least 4.
- myclk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  request to capture a new display word; accepted only when ready=1.
- value  in  4*DIGITS  hex nibbles; nibble i (value[4i+3:4i]) drives digit i, and digit 0 is rightmost.
- dp  in  DIGITS  decimal-point enable per digit, captured with value.
- blank  in  DIGITS  force-blank per digit, captured with value.
- lzb  in  1  leading-zero blanking enable; live, not captured.
- bright  in  4  brightness 0..15; live, not captured.
- an  out  DIGITS  anode enables, active-low; an[i]=0 lights digit i.
- seg  out  8  segments, active-low; bit7=a … bit1=g, bit0=dp.
- ready  out  1  high when a load will be accepted.
- ack  out  1  one-cycle pulse when a captured word becomes the displayed word.

## Operation
- Counters:
  - pre counts 0..2^DIV_LOG2−1 and wraps.
  - On pre wrap, idx advances; idx wraps from DIGITS−1 to 0.
  - A frame boundary is the pre wrap while idx=DIGITS−1.
- Registers:
  - pend holds {value, dp, blank} plus a pend_v flag.
  - disp holds the displayed {value, dp, blank}.
- Handshake:
  - When load=1 and ready=1, pend captures the inputs, pend_v sets and ready drops next cycle.
  - load while ready=0 is ignored; pend is unchanged.
  - At a frame boundary with pend_v=1: disp←pend, pend_v clears, ack=1 for that one cycle, and ready returns to 1 in the same cycle.
  - A load accepted in the boundary cycle itself is transferred at the following boundary, not the current one.
- Decode of nibble n to active-low seg[7:1]:
  - 0→0000001, 1→1001111, 2→0010010, 3→0000110
  - 4→1001100, 5→0100100, 6→0100000, 7→0001111
  - 8→0000000, 9→0000100, A→0001000, b→1100000
  - C→0110001, d→1000010, E→0110000, F→0111000
  - seg[0]=~dp[idx].
- Blanking (a blanked digit outputs seg=8'hFF, dp included):
  - blank[idx]=1 blanks the digit.
  - With lzb=1, digit k (k≥1) is blanked when disp nibbles k..DIGITS−1 are all zero. Digit 0 is never lzb-blanked.
  - A digit not blanked keeps its dp.
- Brightness:
  - The selected anode is asserted only while pre[DIV_LOG2−1:DIV_LOG2−4] ≤ bright; otherwise an is all ones.
  - bright=15 gives the full slot; bright=0 gives 1/16 of the slot.
  - seg is still driven when the anode is off.

## Timing
- Reset values:
  - pre=0, idx=0, disp=0, pend=0, pend_v=0.
  - an=all ones, seg=8'hFF, ready=1, ack=0.
- Outputs:
  - an and seg are registered. They reflect the pre/idx/disp/lzb/bright state of the previous cycle (1-cycle latency).
  - ready and ack are registered.
- First cycle after reset release: an and seg still hold their reset values. an[0]=0 from the second cycle.
- Frame period: DIGITS·2^DIV_LOG2 cycles. The scan order is digit 0,1,…,DIGITS−1, then repeats.
- Load-to-display latency: at least 1 cycle and at most one frame plus 1 cycle. The new segments appear on the cycle after ack.
- Reset asserted mid-frame immediately forces all reset values, and any pending word is discarded.

## Test plan
- Reset, then free-run with DIGITS=4, DIV_LOG2=4, bright=15:
  - After the initial cycle, an steps 1110→1101→1011→0111, each for 16 cycles, and repeats.
  - seg=8'h03 (disp=0, lzb=0).
- load value=16'h12AF, dp=4'b0100, blank=0:
  - ready falls, and ack pulses exactly at the next frame boundary.
  - Digits 0..3 then show 8'h71, 8'h11, 8'h24, 8'h9F; digit 2 has its dp bit cleared.
- lzb=1 with disp=16'h0050:
  - Digits 3 and 2 show 8'hFF, digit 1 shows 8'h49, digit 0 shows 8'h03.
  - With disp=0, only digit 0 is lit (8'h03).
- bright=3: within each 16-cycle slot, the selected anode is low for exactly 4 consecutive cycles (pre 0..3) and high for the other 12.
- Second load while ready=0, then a load in the boundary cycle:
  - The first word displayed is the first load; the second load is ignored.
  - The boundary-cycle load acks one full frame later.
- Assert rst mid-frame with a pending word:
  - Outputs return to reset values immediately.
  - No ack follows, and the scan restarts at digit 0.

Source files
------------

// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Multiplexed seven-segment driver for DIGITS common-anode digits. Each
//   digit slot lasts 2^DIV_LOG2 clocks. The displayed word is swapped only on
//   a frame boundary, so a refresh never shows a mix of two words.
//
// Ports
//   myclk  : system clock, rising edge
//   rst    : asynchronous reset, active high
//   load   : request to capture {value, dp, blank}
//   value  : hex nibble per digit, nibble 0 is the rightmost digit
//   dp     : decimal point per digit (captured with value)
//   blank  : force-blank per digit (captured with value)
//   lzb    : leading-zero blanking enable (live)
//   bright : brightness 0..15 (live)
//   an     : anode enables, active low (registered)
//   seg    : segments {a,b,c,d,e,f,g,dp}, active low (registered)
//   ready  : a load will be accepted
//   ack    : one-cycle pulse when the captured word becomes the displayed word
module seg_scan_display #(
  parameter int DIGITS   = 4,
  parameter int DIV_LOG2 = 4
) (
  input  logic                  myclk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lzb,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  ready,
  output logic                  ack
);

  localparam int            IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DIV_LOG2-1:0] pre;
  logic [IW-1:0]       idx;

  logic [4*DIGITS-1:0] pend_value, disp_value;
  logic [DIGITS-1:0]   pend_dp, pend_blank, disp_dp, disp_blank;
  logic                pend_v;

  logic pre_wrap, frame_end, accept, transfer;

  assign pre_wrap  = (pre == '1);
  assign frame_end = pre_wrap && (idx == IDX_LAST);

  // Handshake: a word is accepted on any cycle where load=1 and ready=1.
  // Accepting clears ready on the next cycle. The pending word moves to the
  // display at the next frame boundary; that same edge raises ack for one
  // cycle and sets ready again. ready is always the inverse of pend_v, so an
  // accept and a transfer can never fall on the same edge, and a word
  // accepted in a boundary cycle waits for the following boundary.
  assign accept   = load && ready;
  assign transfer = frame_end && pend_v;

  // Slot and digit counters
  always_ff @(posedge myclk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= pre + 1'b1;
      if (pre_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Pending/displayed word registers and handshake flags
  always_ff @(posedge myclk or posedge rst) begin
    if (rst) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_v     <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
      ready      <= 1'b1;
      ack        <= 1'b0;
    end else begin
      ack <= transfer;
      if (transfer) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
        pend_v     <= 1'b0;
        ready      <= 1'b1;
      end else if (accept) begin
        pend_value <= value;
        pend_dp    <= dp;
        pend_blank <= blank;
        pend_v     <= 1'b1;
        ready      <= 1'b0;
      end
    end
  end

  // Hex nibble to active-low {a,b,c,d,e,f,g}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  logic [DIGITS-1:0] lz_mask;
  logic              zero_run;
  logic [3:0]        cur_nib;
  logic              cur_dp, cur_off, slot_on;
  logic [DIGITS-1:0] an_nxt;
  logic [7:0]        seg_nxt;

  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_off  = 1'b0;
    an_nxt   = '1;
    lz_mask  = '0;
    zero_run = 1'b1;
    // The top four bits of pre split the slot into 16 brightness steps.
    slot_on  = (pre[DIV_LOG2-1 -: 4] <= bright);

    // lz_mask[k] is set when nibbles k..DIGITS-1 are all zero.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run & (disp_value[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_run;
    end
    lz_mask[0] = 1'b0;  // the rightmost digit always shows

    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = disp_value[4*i +: 4];
        cur_dp  = disp_dp[i];
        cur_off = disp_blank[i] | (lzb & lz_mask[i]);
        if (slot_on) an_nxt[i] = 1'b0;
      end
    end

    seg_nxt = cur_off ? 8'hFF : {hex7(cur_nib), ~cur_dp};
  end

  // Registered pin drivers
  always_ff @(posedge myclk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= 8'hFF;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

  logic        myclk = 1'b0;
  logic        rst   = 1'b0;
  logic        load  = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp    = '0;
  logic [3:0]  blank = '0;
  logic        lzb   = 1'b0;
  logic [3:0]  bright = 4'hF;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        ready;
  logic        ack;

  seg_scan_display #(.DIGITS(4), .DIV_LOG2(4)) dut (
    .myclk (myclk),
    .rst   (rst),
    .load  (load),
    .value (value),
    .dp    (dp),
    .blank (blank),
    .lzb   (lzb),
    .bright(bright),
    .an    (an),
    .seg   (seg),
    .ready (ready),
    .ack   (ack)
  );

  // ---------------- clock / reset ----------------
  always #5 myclk = ~myclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;  // negedges since the last reset release
  logic [11:0] exp_q[$];  // {an, seg} expected for each digit slot

  typedef struct {
    logic [15:0]     v;
    logic [3:0]      d;
    logic [3:0]      b;
    logic            z;
    logic [3:0][7:0] s;  // s[k] = expected seg of digit k
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  task automatic tick();
    @(posedge myclk);
    @(negedge myclk);
    cyc++;
  endtask

  function automatic logic [3:0] an_lit(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  // Expected anodes while free running: output at negedge c shows the slot
  // state of the previous cycle, where pre = (c-1)%16 and digit = (c-1)/16.
  function automatic logic [3:0] scan_an(input int c, input logic [3:0] br);
    int p, d;
    p = (c - 1) % 16;
    d = ((c - 1) / 16) % 4;
    if (p <= int'(br)) return an_lit(d);
    return 4'hF;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v;
    dp    = d;
    blank = b;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic push_word(input logic [3:0][7:0] s);
    for (int k = 0; k < 4; k++) exp_q.push_back({an_lit(k), s[k]});
  endtask

  task automatic wait_ack(input string name, input int limit);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_ack_seen"}, 32'(got), 32'd1);
  endtask

  task automatic scan_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(name, {an, seg}, {scan_an(cyc, bright), 8'h03});
      chk({name, "_ack"}, 32'(ack), 32'd0);
    end
  endtask

  // Scoreboard consumer: one queue entry per digit slot, checked every cycle
  task automatic observe_frame(input string name);
    logic [11:0] e;
    for (int d = 0; d < 4; d++) begin
      if (exp_q.size() == 0) begin
        chk({name, "_queue"}, 32'd0, 32'd1);
        e = '1;
      end else begin
        e = exp_q.pop_front();
      end
      for (int c = 0; c < 16; c++) begin
        tick();
        chk(name, {an, seg}, e);
        if (d == 0 && c == 0) chk({name, "_ack_width"}, 32'(ack), 32'd0);
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{16'h12AF, 4'b0100, 4'b0000, 1'b0, {8'h9F, 8'h24, 8'h11, 8'h71}};
    vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h49, 8'h03}};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
    vecs[3] = '{16'h3456, 4'b1111, 4'b0010, 1'b0, {8'h0C, 8'h98, 8'hFF, 8'h40}};
    vecs[4] = '{16'h789B, 4'b1000, 4'b0000, 1'b1, {8'h1E, 8'h01, 8'h09, 8'hC1}};
    vecs[5] = '{16'hCDE0, 4'b0001, 4'b0000, 1'b1, {8'h63, 8'h85, 8'h61, 8'h02}};
    vecs[6] = '{16'h0008, 4'b0110, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h01}};
    vecs[7] = '{16'h0100, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'h9F, 8'h03, 8'h03}};

    // Reset values
    #2 rst = 1'b1;
    @(negedge myclk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_ack", 32'(ack), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    #1;
    chk("release_an", 32'(an), 32'hF);
    chk("release_seg", 32'(seg), 32'hFF);

    // Free run, full brightness, then bright=3
    scan_check("scan", 128);
    bright = 4'd3;
    scan_check("dim", 64);
    bright = 4'hF;

    // Table-driven words, loaded at random phases in the frame
    for (int i = 0; i < 8; i++) begin
      int t0;
      lzb = vecs[i].z;
      repeat ($urandom_range(0, 30)) tick();
      chk("vec_ready_before", 32'(ready), 32'd1);
      push_word(vecs[i].s);
      drive_load(vecs[i].v, vecs[i].d, vecs[i].b);
      t0 = cyc;
      chk("vec_ready_drop", 32'(ready), 32'd0);
      wait_ack("vec", 80);
      chk("vec_ack_on_boundary", 32'(cyc % 64), 32'd0);
      chk("vec_ack_latency", 32'(cyc - t0 <= 64), 32'd1);
      chk("vec_ready_back", 32'(ready), 32'd1);
      observe_frame("vec_frame");
    end

    // Second load while busy is ignored
    lzb = 1'b0;
    push_word({8'h9F, 8'h9F, 8'h9F, 8'h9F});
    drive_load(16'h1111, 4'b0000, 4'b0000);
    drive_load(16'h2222, 4'b0000, 4'b0000);
    chk("busy_ready", 32'(ready), 32'd0);
    wait_ack("busy", 80);
    observe_frame("busy_frame");

    // Load in the boundary cycle itself: acked one full frame later
    while (cyc % 64 != 63) tick();
    push_word({8'h0D, 8'h0D, 8'h0D, 8'h0D});
    begin
      int t1;
      drive_load(16'h3333, 4'b0000, 4'b0000);
      t1 = cyc;
      chk("bnd_no_early_ack", 32'(ack), 32'd0);
      chk("bnd_ready", 32'(ready), 32'd0);
      wait_ack("bnd", 80);
      chk("bnd_ack_delay", 32'(cyc - t1), 32'd64);
    end
    observe_frame("bnd_frame");
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with a pending word
    lzb    = 1'b0;
    bright = 4'hF;
    repeat ($urandom_range(1, 40)) tick();
    drive_load(16'h8888, 4'b1111, 4'b0000);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_seg", 32'(seg), 32'hFF);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_ack", 32'(ack), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    #1;
    chk("midrst_release_an", 32'(an), 32'hF);
    scan_check("post_rst", 70);
    chk("post_rst_ready", 32'(ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
